tx_chunk_framer: RTL and testbench

Downstream consumer of the virtual-display chunk producer (and any other peripheral with the same request/type/payload interface). It accepts one 16-bit TX chunk plus its 8-bit chunk type, serialises it as a framed byte sequence into the UART transmitter over a valid/ready handshake, and then pulses an acknowledge back to the producer. The acknowledge drives the producer's "chunk consumed" input, which lets the producer advance to its next chunk.

---
 rtl/tx_chunk_framer.sv | 142 ++++++++++++++
 tb/tb_tx_chunk_framer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_chunk_framer.sv
// Frames one 16-bit TX chunk plus its type byte into a SYNC/TYPE/LO/HI byte stream for the UART TX.
// Define TX_CHUNK_FRAMER_CHECKSUM_EN to append an XOR checksum byte (type ^ lo ^ hi).
module tx_chunk_framer #(
  parameter logic [7:0] SYNC_BYTE        = 8'h7E,
  parameter int         FRAME_GAP_CYCLES = 0
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        chunk_request,
  input  logic [7:0]  chunk_type,
  input  logic [15:0] chunk_bytes,
  output logic        chunk_ack,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE,
    SEND_SYNC,
    SEND_TYPE,
    SEND_LO,
    SEND_HI,
`ifdef TX_CHUNK_FRAMER_CHECKSUM_EN
    SEND_CSUM,
`endif
    ACK,
    WAIT_RELEASE,
    GAP
  } state_t;

  localparam logic [7:0] GAP_LOAD = (FRAME_GAP_CYCLES > 0) ? 8'(FRAME_GAP_CYCLES - 1) : 8'd0;

  state_t      state;
  logic [7:0]  type_q;
  logic [15:0] payload_q;
  logic [7:0]  gap_cnt;
  logic        xfer;

  assign xfer = uart_tx_valid && uart_tx_ready;

  // All outputs are registered and updated together with the state they belong to.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state         <= IDLE;
      type_q        <= 8'd0;
      payload_q     <= 16'd0;
      gap_cnt       <= 8'd0;
      chunk_ack     <= 1'b0;
      uart_tx_data  <= 8'd0;
      uart_tx_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      chunk_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (chunk_request) begin
            type_q        <= chunk_type;
            payload_q     <= chunk_bytes;
            state         <= SEND_SYNC;
            uart_tx_data  <= SYNC_BYTE;
            uart_tx_valid <= 1'b1;
            busy          <= 1'b1;
          end
        end
        SEND_SYNC: begin
          if (xfer) begin
            state        <= SEND_TYPE;
            uart_tx_data <= type_q;
          end
        end
        SEND_TYPE: begin
          if (xfer) begin
            state        <= SEND_LO;
            uart_tx_data <= payload_q[7:0];
          end
        end
        SEND_LO: begin
          if (xfer) begin
            state        <= SEND_HI;
            uart_tx_data <= payload_q[15:8];
          end
        end
`ifdef TX_CHUNK_FRAMER_CHECKSUM_EN
        SEND_HI: begin
          if (xfer) begin
            state        <= SEND_CSUM;
            uart_tx_data <= type_q ^ payload_q[7:0] ^ payload_q[15:8];
          end
        end
        SEND_CSUM: begin
          if (xfer) begin
            state         <= ACK;
            uart_tx_data  <= 8'd0;
            uart_tx_valid <= 1'b0;
            chunk_ack     <= 1'b1;
          end
        end
`else
        SEND_HI: begin
          if (xfer) begin
            state         <= ACK;
            uart_tx_data  <= 8'd0;
            uart_tx_valid <= 1'b0;
            chunk_ack     <= 1'b1;
          end
        end
`endif
        ACK: begin
          state <= WAIT_RELEASE;
        end
        // A request still held from the acked frame must drop before anything new is framed.
        WAIT_RELEASE: begin
          if (!chunk_request) begin
            if (FRAME_GAP_CYCLES == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: begin
          state         <= IDLE;
          uart_tx_valid <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_chunk_framer.sv
// Directed self-checking bench for tx_chunk_framer; a second instance with FRAME_GAP_CYCLES=4
// shares the inputs and is checked for the inter-frame gap.
module tb_tx_chunk_framer;

`ifdef TX_CHUNK_FRAMER_CHECKSUM_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        chunk_request = 1'b0;
  logic [7:0]  chunk_type = 8'd0;
  logic [15:0] chunk_bytes = 16'd0;
  logic        uart_tx_ready = 1'b1;
  logic        chunk_ack, uart_tx_valid, busy;
  logic [7:0]  uart_tx_data;
  logic        g_ack, g_valid, g_busy;
  logic [7:0]  g_data;

  int assertCount = 0;
  int failCount = 0;
  int ackCount = 0;
  logic [7:0] rxQ[$];

  tx_chunk_framer dut (
    .CLK(CLK), .reset(reset), .chunk_request(chunk_request), .chunk_type(chunk_type),
    .chunk_bytes(chunk_bytes), .chunk_ack(chunk_ack), .uart_tx_data(uart_tx_data),
    .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready), .busy(busy)
  );

  tx_chunk_framer #(.FRAME_GAP_CYCLES(4)) dut_gap (
    .CLK(CLK), .reset(reset), .chunk_request(chunk_request), .chunk_type(chunk_type),
    .chunk_bytes(chunk_bytes), .chunk_ack(g_ack), .uart_tx_data(g_data),
    .uart_tx_valid(g_valid), .uart_tx_ready(uart_tx_ready), .busy(g_busy)
  );

  always #5 CLK = ~CLK;

  // Record every byte the main instance hands over and every ack it raises.
  always @(posedge CLK) begin
    if (!reset && uart_tx_valid && uart_tx_ready) rxQ.push_back(uart_tx_data);
    if (!reset && chunk_ack) ackCount++;
  end

  function automatic logic [7:0] frameByte(input logic [7:0] t, input logic [15:0] p, input int i);
    case (i)
      0:       frameByte = 8'h7E;
      1:       frameByte = t;
      2:       frameByte = p[7:0];
      3:       frameByte = p[15:8];
      default: frameByte = t ^ p[7:0] ^ p[15:8];
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic [7:0] t, input logic [15:0] p);
    chunk_request = req;
    chunk_type    = t;
    chunk_bytes   = p;
  endtask

  task automatic doReset();
    reset = 1'b1;
    uart_tx_ready = 1'b1;
    applyStimulus(1'b0, 8'd0, 16'd0);
    stepCycle();
    stepCycle();
    reset = 1'b0;
  endtask

  task automatic waitAck(input string tag, input int budget, output int steps);
    steps = 0;
    while (steps < budget) begin
      stepCycle();
      steps++;
      if (chunk_ack) return;
    end
    checkOutput({tag, "_ack_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic checkFrame(input string tag, input logic [7:0] t, input logic [15:0] p);
    checkOutput({tag, "_len"}, rxQ.size(), FRAME_LEN);
    for (int i = 0; i < FRAME_LEN; i++)
      if (i < rxQ.size())
        checkOutput($sformatf("%s_byte%0d", tag, i), rxQ[i], frameByte(t, p, i));
  endtask

  initial begin
    int n;
    int ackStart;
    logic [7:0] pix [4];
    pix[0] = 8'hA5; pix[1] = 8'h5A; pix[2] = 8'hC3; pix[3] = 8'h3C;
    $display("[TB] tx_chunk_framer bench, frame length %0d", FRAME_LEN);

    // Reset state and cycle-exact basic frame
    doReset();
    checkOutput("rst_valid", uart_tx_valid, 0);
    checkOutput("rst_data", uart_tx_data, 0);
    checkOutput("rst_ack", chunk_ack, 0);
    checkOutput("rst_busy", busy, 0);
    applyStimulus(1'b1, 8'h06, 16'h4203);
    for (int i = 0; i < FRAME_LEN; i++) begin
      stepCycle();
      checkOutput($sformatf("basic_valid%0d", i), uart_tx_valid, 1);
      checkOutput($sformatf("basic_data%0d", i), uart_tx_data, frameByte(8'h06, 16'h4203, i));
      checkOutput($sformatf("basic_noack%0d", i), chunk_ack, 0);
    end
    stepCycle();
    checkOutput("basic_ack", chunk_ack, 1);
    checkOutput("basic_ack_valid", uart_tx_valid, 0);
    checkOutput("basic_ack_busy", busy, 1);
    applyStimulus(1'b0, 8'h06, 16'h4203);
    stepCycle();
    checkOutput("basic_ack_once", chunk_ack, 0);
    checkOutput("basic_wait_busy", busy, 1);
    stepCycle();
    checkOutput("basic_idle_busy", busy, 0);

    // Backpressure: ready low for three cycles while the type byte is offered
    doReset();
    rxQ.delete();
    applyStimulus(1'b1, 8'h06, 16'h4203);
    stepCycle();
    stepCycle();
    uart_tx_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("bp_hold_valid%0d", k), uart_tx_valid, 1);
      checkOutput($sformatf("bp_hold_data%0d", k), uart_tx_data, 8'h06);
      stepCycle();
    end
    uart_tx_ready = 1'b1;
    checkOutput("bp_release_data", uart_tx_data, 8'h06);
    waitAck("bp", 20, n);
    checkOutput("bp_ack_delay", n, FRAME_LEN - 1);
    checkFrame("bp", 8'h06, 16'h4203);
    applyStimulus(1'b0, 8'h06, 16'h4203);

    // Held request: no re-framing until release; gap instance waits 4 extra cycles
    doReset();
    applyStimulus(1'b1, 8'h06, 16'h4203);
    waitAck("held", 20, n);
    for (int k = 0; k < 10; k++) begin
      stepCycle();
      checkOutput($sformatf("held_novalid%0d", k), uart_tx_valid, 0);
      checkOutput($sformatf("held_busy%0d", k), busy, 1);
      checkOutput($sformatf("held_gap_novalid%0d", k), g_valid, 0);
    end
    applyStimulus(1'b0, 8'h06, 16'h4203);
    stepCycle();
    checkOutput("held_main_idle", busy, 0);
    checkOutput("held_gap_busy", g_busy, 1);
    applyStimulus(1'b1, 8'h11, 16'h0102);
    stepCycle();
    checkOutput("held_main_resync_valid", uart_tx_valid, 1);
    checkOutput("held_main_resync_data", uart_tx_data, 8'h7E);
    checkOutput("held_gap_wait_valid2", g_valid, 0);
    for (int c = 3; c <= 5; c++) begin
      stepCycle();
      checkOutput($sformatf("held_gap_wait_valid%0d", c), g_valid, 0);
      checkOutput($sformatf("held_gap_wait_busy%0d", c), g_busy, (c < 5) ? 32'd1 : 32'd0);
    end
    stepCycle();
    checkOutput("held_gap_sync_valid", g_valid, 1);
    checkOutput("held_gap_sync_data", g_data, 8'h7E);
    n = 0;
    while (!g_ack && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput("held_gap_ack", g_ack, 1);
    applyStimulus(1'b0, 8'h11, 16'h0102);

    // Payload/type changes during SEND_SYNC must not reach the frame
    doReset();
    rxQ.delete();
    applyStimulus(1'b1, 8'h06, 16'h4203);
    stepCycle();
    applyStimulus(1'b1, 8'hFF, 16'hFFFF);
    waitAck("inflight", 20, n);
    checkFrame("inflight", 8'h06, 16'h4203);
    applyStimulus(1'b0, 8'h06, 16'h4203);

    // Reset during SEND_LO abandons the frame, then a fresh frame goes out cleanly
    doReset();
    applyStimulus(1'b1, 8'h06, 16'h4203);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("mid_lo_data", uart_tx_data, 8'h03);
    reset = 1'b1;
    stepCycle();
    checkOutput("mid_rst_valid", uart_tx_valid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_ack", chunk_ack, 0);
    reset = 1'b0;
    rxQ.delete();
    applyStimulus(1'b1, 8'h06, 16'h0001);
    waitAck("mid_fresh", 20, n);
    checkFrame("mid_fresh", 8'h06, 16'h0001);
    applyStimulus(1'b0, 8'h06, 16'h0001);

    // Producer loop: four chunks, index in the low byte, pixel in the high byte
    doReset();
    ackStart = ackCount;
    for (int idx = 0; idx < 4; idx++) begin
      rxQ.delete();
      applyStimulus(1'b1, 8'h06, {pix[idx], 8'(idx)});
      waitAck($sformatf("prod%0d", idx), 20, n);
      checkFrame($sformatf("prod%0d", idx), 8'h06, {pix[idx], 8'(idx)});
      applyStimulus(1'b0, 8'h06, {pix[idx], 8'(idx)});
      stepCycle();
      stepCycle();
    end
    checkOutput("prod_ack_count", ackCount - ackStart, 4);
    checkOutput("prod_final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
